// File: rtl/generals_turn_engine_if.sv
// Keyboard, board-load and display-read signals of the Generals turn engine.
// The master side (keyboard decoder / loader / display) drives strobes, codes,
// load data and the read address; the engine (slave) returns the registered cell.
interface generals_turn_engine_if #(
    parameter int LOG2_BOARD_W    = 4,
    parameter int LOG2_BOARD_H    = 4,
    parameter int LOG2_PLAYER_CNT = 3,
    parameter int LOG2_MAX_TROOP  = 9
);
    logic                       keyboard_locker;
    logic [2:0]                 keyboard_data;
    logic                       init_we;
    logic [LOG2_BOARD_W-1:0]    init_h;
    logic [LOG2_BOARD_H-1:0]    init_v;
    logic [LOG2_PLAYER_CNT-1:0] init_owner;
    logic [1:0]                 init_type;
    logic [LOG2_MAX_TROOP-1:0]  init_troop;
    logic [LOG2_BOARD_W-1:0]    rd_h;
    logic [LOG2_BOARD_H-1:0]    rd_v;
    logic [LOG2_PLAYER_CNT-1:0] rd_owner;
    logic [1:0]                 rd_type;
    logic [LOG2_MAX_TROOP-1:0]  rd_troop;

    modport master (
        output keyboard_locker, keyboard_data, init_we, init_h, init_v,
               init_owner, init_type, init_troop, rd_h, rd_v,
        input  rd_owner, rd_type, rd_troop
    );

    modport slave (
        input  keyboard_locker, keyboard_data, init_we, init_h, init_v,
               init_owner, init_type, init_troop, rd_h, rd_v,
        output rd_owner, rd_type, rd_troop
    );
endinterface

// File: rtl/generals_turn_engine.sv
// Generals game core: board state, cursor, turn/round bookkeeping, moves,
// attacks, crown capture and the per-round troop-growth sweep.
// Optional feature macro: HALF_MOVE_EN (key code 5 toggles half-move mode).
module generals_turn_engine #(
    parameter int BOARD_W         = 10,
    parameter int BOARD_H         = 10,
    parameter int LOG2_BOARD_W    = 4,
    parameter int LOG2_BOARD_H    = 4,
    parameter int PLAYER_CNT      = 2,
    parameter int LOG2_PLAYER_CNT = 3,
    parameter int LOG2_MAX_TROOP  = 9,
    parameter int LOG2_MAX_ROUND  = 12,
    parameter int GROW_PERIOD     = 25
) (
    input  logic                       clock,
    input  logic                       reset,
    generals_turn_engine_if.slave      bus,
    output logic [LOG2_PLAYER_CNT-1:0] current_player,
    output logic [LOG2_BOARD_W-1:0]    cursor_h,
    output logic [LOG2_BOARD_H-1:0]    cursor_v,
    output logic [1:0]                 cursor_mode,
    output logic [LOG2_MAX_ROUND:0]    round,
    output logic                       busy,
    output logic                       game_over,
    output logic [LOG2_PLAYER_CNT-1:0] winner
);
    localparam int CELLS = BOARD_W * BOARD_H;
    localparam int IDX_W = $clog2(CELLS);
    localparam int TW    = LOG2_MAX_TROOP;
    localparam int PW    = LOG2_PLAYER_CNT;
    localparam int MOD_W = $clog2(GROW_PERIOD + 1);
    localparam logic [1:0] T_TER = 2'd0, T_MTN = 2'd1, T_CROWN = 2'd2, T_CITY = 2'd3;
    localparam logic [1:0] M_SEL = 2'b00, M_MOVE = 2'b10;
`ifdef HALF_MOVE_EN
    localparam logic [1:0] M_HALF = 2'b11;
`endif
    localparam logic [TW-1:0]    TROOP_MAX = '1;
    localparam logic [MOD_W-1:0] MOD_INIT  = (GROW_PERIOD == 1) ? '0 : MOD_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_MOVE_RD, S_MOVE_WR, S_GROW, S_OVER} state_t;

    function automatic logic [TW-1:0] troop_add(input logic [TW-1:0] a, input logic [TW-1:0] b);
        logic [TW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[TW] ? TROOP_MAX : s[TW-1:0];
    endfunction

    function automatic logic [TW-1:0] troop_sub(input logic [TW-1:0] a, input logic [TW-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    function automatic logic [IDX_W-1:0] cell_idx(input logic [LOG2_BOARD_W-1:0] h,
                                                  input logic [LOG2_BOARD_H-1:0] v);
        return IDX_W'(v) * IDX_W'(BOARD_W) + IDX_W'(h);
    endfunction

    logic [PW-1:0] cell_owner [CELLS];
    logic [1:0]    cell_type  [CELLS];
    logic [TW-1:0] cell_troop [CELLS];

    state_t                  state, state_n;
    logic [LOG2_BOARD_W-1:0] cur_h, cur_h_n, nb_h, tgt_h;
    logic [LOG2_BOARD_H-1:0] cur_v, cur_v_n, nb_v, tgt_v;
    logic [1:0]              mode, mode_n;
    logic [PW-1:0]           player, player_n, winner_q, winner_n;
    logic [LOG2_MAX_ROUND:0] round_q, round_n;
    logic [MOD_W-1:0]        round_mod, round_mod_n;
    logic                    over_q, over_n, nb_ok;
    logic [IDX_W-1:0]        cur_i, nb_i, src_idx, tgt_idx, grow_idx, grow_idx_n;
    logic [TW-1:0]           s_troop, t_troop, m, s_troop_new, t_troop_new;
    logic [PW-1:0]           t_owner, t_owner_new;
    logic [1:0]              t_type, t_type_new;
    logic                    capture, mv_reject, lat_en, wr_init, wr_mv, grow_en, grow_inc;

    // Neighbour of the cursor in the direction of the low two key bits
    always_comb begin
        nb_h  = cur_h;
        nb_v  = cur_v;
        nb_ok = 1'b0;
        case (bus.keyboard_data[1:0])
            2'd0: begin nb_ok = (cur_v != '0); nb_v = cur_v - 1'b1; end
            2'd1: begin nb_ok = (cur_v != LOG2_BOARD_H'(BOARD_H - 1)); nb_v = cur_v + 1'b1; end
            2'd2: begin nb_ok = (cur_h != '0); nb_h = cur_h - 1'b1; end
            default: begin nb_ok = (cur_h != LOG2_BOARD_W'(BOARD_W - 1)); nb_h = cur_h + 1'b1; end
        endcase
        cur_i = cell_idx(cur_h, cur_v);
        nb_i  = nb_ok ? cell_idx(nb_h, nb_v) : cur_i;
    end

    // Move resolution from the latched source/target cells
    always_comb begin
        m = troop_sub(s_troop, TW'(1));
`ifdef HALF_MOVE_EN
        if (mode == M_HALF) m = s_troop >> 1;
        mv_reject = (mode == M_HALF) && (m == '0);
`else
        mv_reject = 1'b0;
`endif
        s_troop_new = s_troop - m;
        t_owner_new = t_owner;
        t_type_new  = t_type;
        t_troop_new = t_troop;
        capture     = 1'b0;
        if (t_owner == player) begin
            t_troop_new = troop_add(t_troop, m);
        end else if (m > t_troop) begin
            t_owner_new = player;
            t_troop_new = m - t_troop;
            if (t_type == T_CROWN) begin
                t_type_new = T_CITY;
                capture    = 1'b1;
            end
        end else begin
            t_troop_new = t_troop - m;
        end
        grow_inc = (cell_owner[grow_idx] != '0) &&
                   ((cell_type[grow_idx] == T_CROWN) || (cell_type[grow_idx] == T_CITY) ||
                    ((cell_type[grow_idx] == T_TER) && (round_mod == '0)));
    end

    // Next-state and control decode; keys are only acted on in IDLE
    always_comb begin
        state_n     = state;
        cur_h_n     = cur_h;
        cur_v_n     = cur_v;
        mode_n      = mode;
        player_n    = player;
        round_n     = round_q;
        round_mod_n = round_mod;
        over_n      = over_q;
        winner_n    = winner_q;
        grow_idx_n  = grow_idx;
        lat_en      = 1'b0;
        wr_init     = 1'b0;
        wr_mv       = 1'b0;
        grow_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.init_we) begin
                    wr_init = 1'b1;
                end else if (bus.keyboard_locker) begin
                    case (bus.keyboard_data)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            if (mode == M_SEL) begin
                                if (nb_ok) begin
                                    cur_h_n = nb_h;
                                    cur_v_n = nb_v;
                                end
                            end else if (!nb_ok || cell_type[nb_i] == T_MTN) begin
                                mode_n = M_SEL;
                            end else begin
                                lat_en  = 1'b1;
                                state_n = S_MOVE_RD;
                            end
                        end
                        3'd4: begin
                            if (mode != M_SEL)
                                mode_n = M_SEL;
                            else if (cell_owner[cur_i] == player && cell_troop[cur_i] >= TW'(2))
                                mode_n = M_MOVE;
                        end
`ifdef HALF_MOVE_EN
                        3'd5: begin
                            if (mode != M_SEL) mode_n = {1'b1, ~mode[0]};
                        end
`endif
                        3'd6: begin
                            mode_n = M_SEL;
                            if (player == PW'(PLAYER_CNT)) begin
                                player_n = PW'(1);
                                if (round_q != '1) begin
                                    round_n     = round_q + 1'b1;
                                    round_mod_n = (round_mod == MOD_W'(GROW_PERIOD - 1)) ? '0 : round_mod + 1'b1;
                                end
                                grow_idx_n = '0;
                                state_n    = S_GROW;
                            end else begin
                                player_n = player + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_MOVE_RD: state_n = S_MOVE_WR;
            S_MOVE_WR: begin
                mode_n  = M_SEL;
                state_n = S_IDLE;
                if (!mv_reject) begin
                    wr_mv = 1'b1;
                    if (t_owner_new == player) begin
                        cur_h_n = tgt_h;
                        cur_v_n = tgt_v;
                    end
                    if (capture) begin
                        over_n   = 1'b1;
                        winner_n = player;
                        state_n  = S_OVER;
                    end
                end
            end
            S_GROW: begin
                grow_en = 1'b1;
                if (grow_idx == IDX_W'(CELLS - 1)) state_n = S_IDLE;
                else grow_idx_n = grow_idx + 1'b1;
            end
            default: ;
        endcase
    end

    // Control state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            cur_h     <= '0;
            cur_v     <= '0;
            mode      <= M_SEL;
            player    <= PW'(1);
            round_q   <= (LOG2_MAX_ROUND + 1)'(1);
            round_mod <= MOD_INIT;
            over_q    <= 1'b0;
            winner_q  <= '0;
            grow_idx  <= '0;
        end else begin
            state     <= state_n;
            cur_h     <= cur_h_n;
            cur_v     <= cur_v_n;
            mode      <= mode_n;
            player    <= player_n;
            round_q   <= round_n;
            round_mod <= round_mod_n;
            over_q    <= over_n;
            winner_q  <= winner_n;
            grow_idx  <= grow_idx_n;
        end
    end

    // Latch move endpoints on key accept, then their cell contents in MOVE_RD
    always_ff @(posedge clock) begin
        if (lat_en) begin
            src_idx <= cur_i;
            tgt_idx <= nb_i;
            tgt_h   <= nb_h;
            tgt_v   <= nb_v;
        end
        if (state == S_MOVE_RD) begin
            s_troop <= cell_troop[src_idx];
            t_owner <= cell_owner[tgt_idx];
            t_type  <= cell_type[tgt_idx];
            t_troop <= cell_troop[tgt_idx];
        end
    end

    // Board storage: load, move commit and growth sweep are mutually exclusive by state
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < CELLS; i++) begin
                cell_owner[i] <= '0;
                cell_type[i]  <= T_TER;
                cell_troop[i] <= '0;
            end
        end else if (wr_init) begin
            if (int'(bus.init_h) < BOARD_W && int'(bus.init_v) < BOARD_H) begin
                cell_owner[cell_idx(bus.init_h, bus.init_v)] <= bus.init_owner;
                cell_type[cell_idx(bus.init_h, bus.init_v)]  <= bus.init_type;
                cell_troop[cell_idx(bus.init_h, bus.init_v)] <= bus.init_troop;
            end
        end else if (wr_mv) begin
            cell_troop[src_idx] <= s_troop_new;
            cell_owner[tgt_idx] <= t_owner_new;
            cell_type[tgt_idx]  <= t_type_new;
            cell_troop[tgt_idx] <= t_troop_new;
        end else if (grow_en && grow_inc) begin
            cell_troop[grow_idx] <= troop_add(cell_troop[grow_idx], TW'(1));
        end
    end

    // Registered display read port; off-board addresses read as mountains
    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.rd_owner <= '0;
            bus.rd_type  <= T_TER;
            bus.rd_troop <= '0;
        end else if (int'(bus.rd_h) < BOARD_W && int'(bus.rd_v) < BOARD_H) begin
            bus.rd_owner <= cell_owner[cell_idx(bus.rd_h, bus.rd_v)];
            bus.rd_type  <= cell_type[cell_idx(bus.rd_h, bus.rd_v)];
            bus.rd_troop <= cell_troop[cell_idx(bus.rd_h, bus.rd_v)];
        end else begin
            bus.rd_owner <= '0;
            bus.rd_type  <= T_MTN;
            bus.rd_troop <= '0;
        end
    end

    assign current_player = player;
    assign cursor_h       = cur_h;
    assign cursor_v       = cur_v;
    assign cursor_mode    = mode;
    assign round          = round_q;
    assign busy           = (state == S_MOVE_RD) || (state == S_MOVE_WR) || (state == S_GROW);
    assign game_over      = over_q;
    assign winner         = winner_q;
endmodule
